// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the add/subtract odd-constant sequencer.
// The FSM state encoding, op codes and constant decode live here.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Select 0..3 maps to the odd constants 1, 3, 5, 7.
  function automatic logic [2:0] const_value(input logic [1:0] sel);
    return {sel, 1'b1};
  endfunction

endpackage

// File: rtl/addsub_const_step.sv
// Combinational single-step datapath: acc +/- K via a ripple-carry chain.
// Subtraction adds the two's complement of K, so carry-out means "no borrow".
module addsub_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module addsub_const_step
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       sel,
  input  logic             op,
  output logic [WIDTH-1:0] next_acc,
  output logic             step_wrap
);

  logic [WIDTH-1:0] k_ext;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH:0]   carry;

  assign k_ext     = WIDTH'(const_value(sel));
  assign b_operand = (op == OP_SUB) ? (~k_ext + WIDTH'(1)) : k_ext;
  assign carry[0]  = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    addsub_full_adder u_fa (
      .a   (acc[i]),
      .b   (b_operand[i]),
      .cin (carry[i]),
      .sum (next_acc[i]),
      .cout(carry[i+1])
    );
  end

  // A missing carry-out on subtraction is a borrow, i.e. an underflow.
  assign step_wrap = (op == OP_SUB) ? ~carry[WIDTH] : carry[WIDTH];

endmodule

// File: rtl/addsub_const_sequencer.sv
// Runs a programmed number of add/subtract-constant steps on an accumulator,
// with a start/busy/done handshake and a sticky per-run wrap flag.
module addsub_const_sequencer
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] init_value,
  input  logic [1:0]       const_sel,
  input  logic             op,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wrapped
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       sel_q, sel_d;
  logic             op_q, op_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             run_wrap_q, run_wrap_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] step_acc;
  logic             step_wrap;

  addsub_const_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc_q),
    .sel      (sel_q),
    .op       (op_q),
    .next_acc (step_acc),
    .step_wrap(step_wrap)
  );

  // run_wrap accumulates during the run; the visible wrapped flag and result
  // only change together on DONE entry.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sel_d       = sel_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    run_wrap_d  = run_wrap_q;
    result_d    = result_q;
    wrapped_d   = wrapped_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = init_value;
          sel_d       = const_sel;
          op_d        = op;
          remaining_d = steps;
          run_wrap_d  = 1'b0;
          if (steps != '0) begin
            state_d = RUN;
          end else begin
            state_d   = DONE;
            result_d  = init_value;
            wrapped_d = 1'b0;
          end
        end
      end
      RUN: begin
        acc_d       = step_acc;
        remaining_d = remaining_q - CNT_W'(1);
        run_wrap_d  = run_wrap_q | step_wrap;
        if (remaining_q == CNT_W'(1)) begin
          state_d   = DONE;
          result_d  = step_acc;
          wrapped_d = run_wrap_q | step_wrap;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sel_q       <= '0;
      op_q        <= OP_ADD;
      remaining_q <= '0;
      run_wrap_q  <= 1'b0;
      result_q    <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sel_q       <= sel_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      run_wrap_q  <= run_wrap_d;
      result_q    <= result_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_addsub_const_sequencer.sv
// Directed, table-driven bench for addsub_const_sequencer with hand-computed
// expectations plus sequences for ignored start and asynchronous reset.
module tb_addsub_const_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] init_value;
  logic [1:0] const_sel;
  logic       op;
  logic [3:0] steps;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       wrapped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] init;
    logic [1:0] sel;
    logic       op;
    logic [3:0] steps;
    logic [7:0] exp_result;
    logic       exp_wrapped;
  } vec_t;

  vec_t vecs[8];

  addsub_const_sequencer #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .init_value(init_value),
    .const_sel (const_sel),
    .op        (op),
    .steps     (steps),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Raises start for one cycle (cycle 0) with the given configuration.
  task automatic applyStimulus(input logic [7:0] i_init, input logic [1:0] i_sel,
                               input logic i_op, input logic [3:0] i_steps);
    @(posedge clk);
    #1;
    start      = 1'b1;
    init_value = i_init;
    const_sel  = i_sel;
    op         = i_op;
    steps      = i_steps;
  endtask

  initial begin
    vecs[0] = '{8'd10,  2'd1, 1'b0, 4'd4,  8'd22,  1'b0};
    vecs[1] = '{8'd2,   2'd2, 1'b1, 4'd1,  8'hFD,  1'b1};
    vecs[2] = '{8'd250, 2'd3, 1'b0, 4'd2,  8'd8,   1'b1};
    vecs[3] = '{8'h5A,  2'd0, 1'b0, 4'd0,  8'h5A,  1'b0};
    vecs[4] = '{8'h10,  2'd3, 1'b1, 4'd3,  8'hFB,  1'b1};
    vecs[5] = '{8'h00,  2'd0, 1'b1, 4'd0,  8'h00,  1'b0};
    vecs[6] = '{8'h80,  2'd2, 1'b0, 4'd15, 8'hCB,  1'b0};
    vecs[7] = '{8'hFF,  2'd0, 1'b0, 4'd1,  8'h00,  1'b1};

    reset      = 1'b1;
    start      = 1'b0;
    init_value = 8'h00;
    const_sel  = 2'd0;
    op         = 1'b0;
    steps      = 4'd0;

    #3;
    checkOutput("reset_busy", 8'(busy), 8'h00);
    checkOutput("reset_done", 8'(done), 8'h00);
    checkOutput("reset_result", result, 8'h00);
    checkOutput("reset_wrapped", 8'(wrapped), 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      int n;
      n = int'(vecs[v].steps);
      applyStimulus(vecs[v].init, vecs[v].sel, vecs[v].op, vecs[v].steps);
      @(negedge clk);
      checkOutput($sformatf("v%0d_c0_busy", v), 8'(busy), 8'h00);
      checkOutput($sformatf("v%0d_c0_done", v), 8'(done), 8'h00);
      for (int c = 1; c <= n + 2; c++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d_c%0d_busy", v, c), 8'(busy), 8'(c >= 1 && c <= n));
        checkOutput($sformatf("v%0d_c%0d_done", v, c), 8'(done), 8'(c == n + 1));
        if (c >= n + 1) begin
          checkOutput($sformatf("v%0d_c%0d_result", v, c), result, vecs[v].exp_result);
          checkOutput($sformatf("v%0d_c%0d_wrapped", v, c), 8'(wrapped), 8'(vecs[v].exp_wrapped));
        end
      end
    end

    // A start arriving mid-run with a different configuration must be ignored.
    applyStimulus(8'h00, 2'd0, 1'b1, 4'd15);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        start      = 1'b1;
        init_value = 8'h55;
        const_sel  = 2'd3;
        op         = 1'b0;
        steps      = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("ign_c%0d_busy", c), 8'(busy), 8'(c <= 15));
      checkOutput($sformatf("ign_c%0d_done", c), 8'(done), 8'(c == 16));
      if (c == 16) begin
        checkOutput("ign_result", result, 8'hF1);
        checkOutput("ign_wrapped", 8'(wrapped), 8'h01);
      end
    end

    // Asynchronous reset in the middle of an 8-step run.
    applyStimulus(8'h33, 2'd1, 1'b0, 4'd8);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("rst_c%0d_busy", c), 8'(busy), 8'h01);
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_busy", 8'(busy), 8'h00);
    checkOutput("rst_async_done", 8'(done), 8'h00);
    checkOutput("rst_async_result", result, 8'h00);
    checkOutput("rst_async_wrapped", 8'(wrapped), 8'h00);
    @(negedge clk);
    checkOutput("rst_hold_done", 8'(done), 8'h00);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_idle%0d_done", c), 8'(done), 8'h00);
      checkOutput($sformatf("rst_idle%0d_busy", c), 8'(busy), 8'h00);
    end

    applyStimulus(8'h01, 2'd0, 1'b0, 4'd1);
    @(negedge clk);
    checkOutput("post_c0_busy", 8'(busy), 8'h00);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("post_c1_busy", 8'(busy), 8'h01);
    checkOutput("post_c1_done", 8'(done), 8'h00);
    @(negedge clk);
    checkOutput("post_c2_done", 8'(done), 8'h01);
    checkOutput("post_c2_result", result, 8'h02);
    checkOutput("post_c2_wrapped", 8'(wrapped), 8'h00);
    @(negedge clk);
    checkOutput("post_c3_done", 8'(done), 8'h00);
    checkOutput("post_c3_result", result, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
